// File: rtl/maze_pkg.sv
// maze_pkg
// Shared definitions for the maze walker: grid geometry, goal cell,
// coordinate width, the 2-bit move encoding and the walker FSM states.
// No ports; imported by maze_step and maze_walker.
package maze_pkg;

    // The grid is GRID_DIM x GRID_DIM cells, addressed as bit y*8+x of the
    // wall map.
    localparam int GRID_DIM = 8;
    localparam int CELL_W   = 3;

    // Coordinates carry one spare bit, so stepping below 0 or past 7 gives a
    // value of 8..15.  That value is then caught as out of range instead of
    // wrapping back onto the grid.
    localparam int COORD_W = 4;

    localparam logic [COORD_W-1:0] GOAL_X = 4'd7;
    localparam logic [COORD_W-1:0] GOAL_Y = 4'd7;

    typedef enum logic [1:0] {
        UP    = 2'b00,   // y - 1
        RIGHT = 2'b01,   // x + 1
        DOWN  = 2'b10,   // y + 1
        LEFT  = 2'b11    // x - 1
    } move_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/maze_step.sv
// maze_step
// Purely combinational single-step evaluator for the maze walker.
// Ports:
//   x, y      : current position (COORD_W bits, always on-grid)
//   move      : move to apply
//   wall_map  : 64-bit wall bitmap, bit y*8+x set means wall
//   x_next,
//   y_next    : candidate position after the move (only meaningful when hit=0)
//   hit       : candidate is off-grid or on a wall cell
module maze_step
    import maze_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  move_t              move,
    input  logic [63:0]        wall_map,
    output logic [COORD_W-1:0] x_next,
    output logic [COORD_W-1:0] y_next,
    output logic               hit
);

    logic                    off_grid;
    logic [2*CELL_W-1:0]     cell_idx;
    logic                    on_wall;

    // Candidate position uses full COORD_W arithmetic.  Stepping left or up
    // from 0 therefore lands on 15 rather than wrapping to 7.
    always_comb begin
        x_next = x;
        y_next = y;
        unique case (move)
            UP:      y_next = y - COORD_W'(1);
            RIGHT:   x_next = x + COORD_W'(1);
            DOWN:    y_next = y + COORD_W'(1);
            LEFT:    x_next = x - COORD_W'(1);
            default: ;
        endcase
    end

    // The start cell (0,0) is always free, whatever its wall bit says.
    always_comb begin
        off_grid = (x_next >= COORD_W'(GRID_DIM)) || (y_next >= COORD_W'(GRID_DIM));
        cell_idx = {y_next[CELL_W-1:0], x_next[CELL_W-1:0]};
        on_wall  = wall_map[cell_idx] && (cell_idx != '0);
        hit      = off_grid || on_wall;
    end

endmodule

// File: rtl/maze_walker.sv
// maze_walker
// Walks a genome of 2-bit moves through an 8x8 maze, starting at (0,0).
// A run ends on a collision, on reaching the goal (7,7), or after the last
// move.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a run (accepted only in IDLE while done is low)
//   genome     : 2*GENOME_LEN bits; move i in bits [2i+1:2i]
//   wall_map   : 64-bit wall bitmap, bit y*8+x
//   busy       : high while a run is in progress
//   done       : one-cycle pulse when the result outputs become valid
//   x_fin,
//   y_fin      : final position
//   alive      : walker finished without colliding
//   moves_used : moves consumed, including the one that ended the run
module maze_walker
    import maze_pkg::*;
#(
    parameter int GENOME_LEN = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [2*GENOME_LEN-1:0]         genome,
    input  logic [63:0]                     wall_map,
    output logic                            busy,
    output logic                            done,
    output logic [COORD_W-1:0]              x_fin,
    output logic [COORD_W-1:0]              y_fin,
    output logic                            alive,
    output logic [$clog2(GENOME_LEN+1)-1:0] moves_used
);

    localparam int MU_W = $clog2(GENOME_LEN+1);
    localparam logic [MU_W-1:0] LAST_IDX = MU_W'(GENOME_LEN-1);

    state_t                  state;
    state_t                  state_next;
    logic [2*GENOME_LEN-1:0] genome_q;
    logic [63:0]             walls_q;
    logic [COORD_W-1:0]      x_next;
    logic [COORD_W-1:0]      y_next;
    logic                    hit;
    logic                    goal;
    logic                    last;
    logic                    load;
    logic                    step;
    logic                    finish;

    // The genome is shifted right after each move, so the move to apply is
    // always in the low two bits.
    maze_step u_step (
        .x        (x_fin),
        .y        (y_fin),
        .move     (move_t'(genome_q[1:0])),
        .wall_map (walls_q),
        .x_next   (x_next),
        .y_next   (y_next),
        .hit      (hit)
    );

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.  A start that arrives in the same cycle as done is
    // ignored.  The result must stay readable for at least that cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        goal       = !hit && (x_next == GOAL_X) && (y_next == GOAL_Y);
        last       = (moves_used == LAST_IDX);
        unique case (state)
            IDLE: begin
                if (start && !done) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (hit || goal || last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The result registers also serve as the working position and counter.
    // Between done and the next accepted start, nothing updates them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            genome_q   <= '0;
            walls_q    <= '0;
            x_fin      <= '0;
            y_fin      <= '0;
            alive      <= 1'b0;
            moves_used <= '0;
            done       <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                genome_q   <= genome;
                walls_q    <= wall_map;
                x_fin      <= '0;
                y_fin      <= '0;
                alive      <= 1'b1;
                moves_used <= '0;
            end else if (step) begin
                genome_q   <= genome_q >> 2;
                moves_used <= moves_used + MU_W'(1);
                if (hit) begin
                    alive <= 1'b0;
                end else begin
                    x_fin <= x_next;
                    y_fin <= y_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_maze_walker.sv
// tb_maze_walker
// Self-checking bench for maze_walker.  Each run pushes its expected result
// onto a scoreboard queue.  The entry is popped and compared when done pulses.
module tb_maze_walker;

    typedef struct packed {
        logic [7:0] cycles;
        logic [3:0] x;
        logic [3:0] y;
        logic       alive;
        logic [4:0] moves;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] genome = '0;
    logic [63:0] wall_map = '0;
    logic        busy;
    logic        done;
    logic [3:0]  x_fin;
    logic [3:0]  y_fin;
    logic        alive;
    logic [4:0]  moves_used;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    maze_walker #(.GENOME_LEN(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .genome     (genome),
        .wall_map   (wall_map),
        .busy       (busy),
        .done       (done),
        .x_fin      (x_fin),
        .y_fin      (y_fin),
        .alive      (alive),
        .moves_used (moves_used)
    );

    always #5 clk = ~clk;

    // Reference walker written with plain integers, independent of the RTL's
    // 4-bit arithmetic.
    function automatic exp_t model_walk(input logic [31:0] g, input logic [63:0] w);
        exp_t e;
        int   px, py, nx, ny;
        px = 0; py = 0;
        e = '0;
        e.alive = 1'b1;
        e.moves = 5'd16;
        e.cycles = 8'd16;
        for (int i = 0; i < 16; i++) begin
            nx = px; ny = py;
            case (g[2*i +: 2])
                2'b00: ny = py - 1;
                2'b01: nx = px + 1;
                2'b10: ny = py + 1;
                default: nx = px - 1;
            endcase
            if (nx < 0 || nx > 7 || ny < 0 || ny > 7 ||
                (w[ny*8 + nx] && !(nx == 0 && ny == 0))) begin
                e.alive = 1'b0;
                e.moves = 5'(i + 1);
                e.cycles = 8'(i + 1);
                break;
            end
            px = nx; py = ny;
            if (px == 7 && py == 7) begin
                e.moves = 5'(i + 1);
                e.cycles = 8'(i + 1);
                break;
            end
        end
        e.x = 4'(px);
        e.y = 4'(py);
        return e;
    endfunction

    // Start one run and wait, for a bounded time, for done.  The task returns
    // the observed result, or all ones if done never came.  When
    // perturb_cyc >= 0, start is pulsed in that cycle and the inputs are
    // scrambled for one cycle.  Neither may affect the run.  The task
    // returns at the negedge where done is high.
    task automatic run_genome(input logic [31:0] g, input logic [63:0] w,
                              input int perturb_cyc, output exp_t obs);
        int cyc;
        bit seen;
        @(negedge clk);
        genome = g; wall_map = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; seen = 0;
        obs = '1;
        while (!seen && cyc < 40) begin
            if (cyc == perturb_cyc) begin
                start = 1'b1; genome = ~g; wall_map = '1;
            end
            @(negedge clk);
            start = 1'b0; genome = g; wall_map = w;
            cyc++;
            if (done) begin
                seen = 1;
                obs.cycles = 8'(cyc);
                obs.x = x_fin;
                obs.y = y_fin;
                obs.alive = alive;
                obs.moves = moves_used;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, x_fin, y_fin, alive, moves_used} !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got busy=%b done=%b x=%0d y=%0d alive=%b moves=%0d expected all 0",
                     busy, done, x_fin, y_fin, alive, moves_used);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset busy=%b expected 0", busy);
        end
    endtask

    task automatic test_right_wall;
        exp_t obs, exp;
        sb.push_back('{cycles: 8'd8, x: 4'd7, y: 4'd0, alive: 1'b0, moves: 5'd8});
        run_genome(32'h5555_5555, 64'h0, -1, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL right_wall got cyc=%0d (%0d,%0d) alive=%b moves=%0d expected cyc=%0d (%0d,%0d) alive=%b moves=%0d",
                     obs.cycles, obs.x, obs.y, obs.alive, obs.moves, exp.cycles, exp.x, exp.y, exp.alive, exp.moves);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_one_cycle done=%b expected 0", done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({x_fin, y_fin, alive, moves_used} !== {4'd7, 4'd0, 1'b0, 5'd8}) begin
            failures++;
            $display("[TB] FAIL result_hold got (%0d,%0d) alive=%b moves=%0d expected (7,0) alive=0 moves=8",
                     x_fin, y_fin, alive, moves_used);
        end
    endtask

    task automatic test_goal;
        exp_t        obs, exp;
        logic [31:0] g;
        for (int i = 0; i < 16; i++)
            g[2*i +: 2] = (i < 7) ? 2'b01 : (i < 14) ? 2'b10 : 2'b00;
        sb.push_back('{cycles: 8'd14, x: 4'd7, y: 4'd7, alive: 1'b1, moves: 5'd14});
        run_genome(g, 64'h0, -1, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL goal got cyc=%0d (%0d,%0d) alive=%b moves=%0d expected cyc=%0d (%0d,%0d) alive=%b moves=%0d",
                     obs.cycles, obs.x, obs.y, obs.alive, obs.moves, exp.cycles, exp.x, exp.y, exp.alive, exp.moves);
        end
    endtask

    task automatic test_wall_hit;
        exp_t obs, exp;
        sb.push_back('{cycles: 8'd1, x: 4'd0, y: 4'd0, alive: 1'b0, moves: 5'd1});
        run_genome(32'h5555_5555, 64'h2, -1, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL wall_hit got cyc=%0d (%0d,%0d) alive=%b moves=%0d expected cyc=%0d (%0d,%0d) alive=%b moves=%0d",
                     obs.cycles, obs.x, obs.y, obs.alive, obs.moves, exp.cycles, exp.x, exp.y, exp.alive, exp.moves);
        end
    endtask

    task automatic test_underflow;
        exp_t obs, exp;
        sb.push_back('{cycles: 8'd1, x: 4'd0, y: 4'd0, alive: 1'b0, moves: 5'd1});
        run_genome(32'h0000_0000, 64'h0, -1, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL y_underflow got cyc=%0d (%0d,%0d) alive=%b moves=%0d expected cyc=%0d (%0d,%0d) alive=%b moves=%0d",
                     obs.cycles, obs.x, obs.y, obs.alive, obs.moves, exp.cycles, exp.x, exp.y, exp.alive, exp.moves);
        end
    endtask

    task automatic test_back_to_back;
        exp_t obs, exp;
        // RIGHT, LEFT repeated; wall bit 0 set must be ignored
        sb.push_back('{cycles: 8'd16, x: 4'd0, y: 4'd0, alive: 1'b1, moves: 5'd16});
        run_genome(32'hDDDD_DDDD, 64'h1, 5, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL alternate_full got cyc=%0d (%0d,%0d) alive=%b moves=%0d expected cyc=%0d (%0d,%0d) alive=%b moves=%0d",
                     obs.cycles, obs.x, obs.y, obs.alive, obs.moves, exp.cycles, exp.x, exp.y, exp.alive, exp.moves);
        end
        // start while done is high must not be accepted
        start = 1'b1;
        genome = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, x_fin, y_fin, alive, moves_used} !== {1'b0, 4'd0, 4'd0, 1'b1, 5'd16}) begin
            failures++;
            $display("[TB] FAIL start_during_done busy=%b (%0d,%0d) alive=%b moves=%0d expected busy=0 (0,0) alive=1 moves=16",
                     busy, x_fin, y_fin, alive, moves_used);
        end
    endtask

    task automatic test_reset_mid_run;
        exp_t        obs, exp;
        logic [31:0] g;
        bit          saw_done;
        @(negedge clk);
        genome = 32'h5555_5555; wall_map = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_mid_run busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, x_fin, y_fin, alive, moves_used} !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid_run got busy=%b done=%b x=%0d y=%0d alive=%b moves=%0d expected all 0",
                     busy, done, x_fin, y_fin, alive, moves_used);
        end
        rst_n = 1'b1;
        saw_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_done_after_abort saw_done=%b expected 0", saw_done);
        end
        for (int i = 0; i < 16; i++)
            g[2*i +: 2] = (i < 7) ? 2'b01 : (i < 14) ? 2'b10 : 2'b00;
        sb.push_back('{cycles: 8'd14, x: 4'd7, y: 4'd7, alive: 1'b1, moves: 5'd14});
        run_genome(g, 64'h0, -1, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL run_after_abort got cyc=%0d (%0d,%0d) alive=%b moves=%0d expected cyc=%0d (%0d,%0d) alive=%b moves=%0d",
                     obs.cycles, obs.x, obs.y, obs.alive, obs.moves, exp.cycles, exp.x, exp.y, exp.alive, exp.moves);
        end
    endtask

    task automatic test_random;
        exp_t        obs, exp;
        logic [31:0] g;
        logic [63:0] w;
        for (int n = 0; n < 8; n++) begin
            g = $urandom;
            w = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            sb.push_back(model_walk(g, w));
            run_genome(g, w, -1, obs);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL random_%0d g=%h w=%h got cyc=%0d (%0d,%0d) alive=%b moves=%0d expected cyc=%0d (%0d,%0d) alive=%b moves=%0d",
                         n, g, w, obs.cycles, obs.x, obs.y, obs.alive, obs.moves, exp.cycles, exp.x, exp.y, exp.alive, exp.moves);
            end
        end
    endtask

    initial begin
        test_reset();
        test_right_wall();
        test_goal();
        test_wall_hit();
        test_underflow();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_walker.md
MAZE_WALKER -- requirements
Module: maze_walker

Interface
REQ-001 SHALL have parameter GENOME_LEN, default 16, meaning the number of 2-bit moves per genome.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to evaluate one genome; sampled only in IDLE.
REQ-005 SHALL have port genome, input, 2*GENOME_LEN, move list; move i in bits [2i+1:2i], move 0 first.
REQ-006 SHALL have port wall_map, input, 64, 1 = wall at cell (x,y), bit index y*8+x.
REQ-007 SHALL have port busy, output, 1, high while in RUN.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when a result becomes valid.
REQ-009 SHALL have port x_fin, output, 4, final x coordinate, bit 3 always 0.
REQ-010 SHALL have port y_fin, output, 4, final y coordinate, bit 3 always 0.
REQ-011 SHALL have port alive, output, 1, walker did not collide.
REQ-012 SHALL have port moves_used, output, clog2(GENOME_LEN+1), moves consumed including the terminating move.

Function
REQ-013 SHALL implement two states: IDLE and RUN.
REQ-014 SHALL, in IDLE with start=1 at an edge: latch genome and wall_map; set position (0,0), alive=1, moves_used=0; enter RUN.
REQ-015 SHALL, in RUN, consume exactly one move per clock, in order from move 0.
REQ-016 SHALL decode moves as 00 = y-1, 01 = x+1, 10 = y+1, 11 = x-1.
REQ-017 SHALL treat a candidate position outside 0..7 on either axis, or on a cell with its wall bit set, as a collision.
REQ-018 SHALL, on collision: keep the prior position, clear alive, terminate.
REQ-019 SHALL, on a legal move: update the position; terminate if the new position is (7,7).
REQ-020 SHALL terminate after move GENOME_LEN-1 if not terminated earlier.
REQ-021 SHALL, at the terminating edge: register final outputs, assert done for exactly one cycle, return to IDLE.
REQ-022 SHALL give latency k cycles: the k-th move (1-based) ends the run, so done is high in cycle k after the start edge; full run = GENOME_LEN.
REQ-023 SHALL ignore start while busy=1; start in the same cycle done is high is ignored, and acceptance requires start in IDLE.
REQ-024 SHALL hold x_fin, y_fin, alive and moves_used stable from done until the next accepted start.
REQ-025 SHALL ignore wall bit 0 (cell 0,0); the start cell is always free.
REQ-026 SHALL NOT let genome/wall_map changes during RUN affect the result, since the latched copies are used.
REQ-027 SHALL compute coordinates with 4-bit arithmetic so that an underflow from 0 is detected as a collision rather than a wrap-around.

Reset
REQ-028 SHALL, with rst_n=0 at an edge, force state IDLE, busy=0, done=0, x_fin=0, y_fin=0, alive=0, moves_used=0.
REQ-029 SHALL, on reset mid-RUN, abort the run with no done pulse.

Structure
REQ-030 SHALL take these from shared package maze_pkg: GRID_DIM=8, GOAL_X=7, GOAL_Y=7, COORD_W=4, and the move-encoding enum (UP, RIGHT, DOWN, LEFT).
REQ-031 SHALL place next-position and collision logic in combinational sub-module maze_step (inputs: position, move, wall_map; outputs: next position, hit).

Verification
REQ-032 SHALL cover: empty walls, genome of 16 x RIGHT -> collision at move 8, done at cycle 8, x_fin=7, y_fin=0, alive=0, moves_used=8.
REQ-033 SHALL cover: empty walls, 7 x RIGHT then 7 x DOWN then 2 x UP -> goal at move 14, done at cycle 14, (7,7), alive=1, moves_used=14.
REQ-034 SHALL cover: wall at (1,0) (bit 1), move 0 = RIGHT -> done at cycle 1, (0,0), alive=0, moves_used=1.
REQ-035 SHALL cover: move 0 = UP -> y underflow collision, done at cycle 1, (0,0), alive=0.
REQ-036 SHALL cover: empty walls, alternating RIGHT/LEFT x16 -> done at cycle 16, (0,0), alive=1, moves_used=16; start pulsed mid-run is ignored.
REQ-037 SHALL cover: rst_n low at cycle 5 of a run -> no done pulse, all outputs 0; a new start afterwards runs normally.
